// File: rtl/clock_pkg.sv
// Shared definitions for the indicator LED scheduler: state encoding, owner codes and
// time-of-day constants.
package clock_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StChime = 2'd1,
    StAlarm = 2'd2
  } state_e;

  localparam logic [1:0] OWN_NONE  = 2'b00;
  localparam logic [1:0] OWN_CHIME = 2'b01;
  localparam logic [1:0] OWN_ALARM = 2'b10;

  localparam int unsigned SEC_PER_MIN = 60;
  localparam int unsigned MAX_FLASH   = 12;

endpackage

// File: rtl/chime_hour_decode.sv
// Maps the current hour to the chime toggle count, the start second and the quiet-hour
// mute flag. Quiet hours are honoured only when CHIME_QUIET_EN is defined.
module chime_hour_decode
  import clock_pkg::*;
#(
  parameter int unsigned QUIET_START = 23,
  parameter int unsigned QUIET_END   = 7
) (
  input  logic [4:0] i_hour,
  output logic [4:0] o_toggles,
  output logic [5:0] o_start_sec,
  output logic       o_mute
);

`ifdef CHIME_QUIET_EN
  localparam logic QuietEn = 1'b1;
`else
  localparam logic QuietEn = 1'b0;
`endif

  logic [4:0] w_next;
  logic [3:0] w_flash;

  always_comb begin
    w_next  = (i_hour >= 5'd23) ? 5'd0 : i_hour + 5'd1;
    w_flash = (w_next >= 5'd12) ? 4'(w_next - 5'd12) : w_next[3:0];
    if (w_flash == 4'd0) begin
      w_flash = 4'(MAX_FLASH);
    end
    o_toggles   = {w_flash, 1'b0};
    o_start_sec = 6'(SEC_PER_MIN) - {1'b0, o_toggles};
    // Muted window wraps through midnight: [QUIET_START, 24) plus [0, QUIET_END).
    o_mute      = QuietEn & ((w_next >= 5'(QUIET_START)) | (w_next < 5'(QUIET_END)));
  end

endmodule

// File: rtl/chime_scheduler.sv
// Shares the single indicator LED between the hourly chime and the daily alarm.
// Optional quiet hours for the chime: define CHIME_QUIET_EN.
module chime_scheduler
  import clock_pkg::*;
#(
  parameter int unsigned ALARM_LEN   = 60,
  parameter int unsigned QUIET_START = 23,
  parameter int unsigned QUIET_END   = 7
) (
  input  logic       clk_1hz,
  input  logic       rst_n,
  input  logic [4:0] hour,
  input  logic [5:0] minute,
  input  logic [5:0] second,
  input  logic       set_mode,
  input  logic       chime_en,
  input  logic       alarm_en,
  input  logic [4:0] alarm_hh,
  input  logic [5:0] alarm_mm,
  input  logic       alarm_stop,
  output logic       led,
  output logic       busy,
  output logic [1:0] owner,
  output logic       chime_skip
);

  localparam logic [6:0] AlarmLenC = 7'(ALARM_LEN);

  state_e     r_state, w_state_nxt;
  logic [6:0] r_cnt, w_cnt_nxt;
  logic       r_pend, w_pend_nxt;
  logic       r_led, w_led_nxt;
  logic       r_skip, w_skip_nxt;

  logic [4:0] w_toggles;
  logic [5:0] w_start_sec;
  logic       w_mute;
  logic       w_chime_trig;
  logic       w_alarm_trig;

  chime_hour_decode #(
    .QUIET_START(QUIET_START),
    .QUIET_END  (QUIET_END)
  ) u_decode (
    .i_hour     (hour),
    .o_toggles  (w_toggles),
    .o_start_sec(w_start_sec),
    .o_mute     (w_mute)
  );

  assign w_chime_trig = chime_en & ~set_mode & ~w_mute & (minute == 6'd59) &
                        (second == w_start_sec);
  assign w_alarm_trig = alarm_en & ~set_mode & (hour == alarm_hh) & (minute == alarm_mm) &
                        (second == 6'd0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_led_nxt   = r_led;
    w_skip_nxt  = 1'b0;
    if (set_mode) begin
      w_state_nxt = StIdle;
      w_cnt_nxt   = 7'd0;
      w_pend_nxt  = 1'b0;
      w_led_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_chime_trig) begin
            w_state_nxt = StChime;
            w_cnt_nxt   = {2'b00, w_toggles};
          end else if (w_alarm_trig) begin
            w_state_nxt = StAlarm;
            w_cnt_nxt   = AlarmLenC;
          end
        end
        StChime: begin
          w_led_nxt = ~r_led;
          w_cnt_nxt = r_cnt - 7'd1;
          if (w_alarm_trig) begin
            w_pend_nxt = 1'b1;
          end
          if (r_cnt == 7'd1) begin
            // Last chime toggle lands on hh:00:00; a pending alarm takes over immediately.
            w_pend_nxt = 1'b0;
            if (r_pend | w_alarm_trig) begin
              w_state_nxt = StAlarm;
              w_cnt_nxt   = AlarmLenC;
            end else begin
              w_state_nxt = StIdle;
            end
          end
        end
        StAlarm: begin
          w_skip_nxt = w_chime_trig;
          if (alarm_stop) begin
            w_state_nxt = StIdle;
            w_cnt_nxt   = 7'd0;
            w_led_nxt   = 1'b0;
          end else begin
            w_led_nxt = ~r_led;
            w_cnt_nxt = r_cnt - 7'd1;
            if (r_cnt == 7'd1) begin
              w_state_nxt = StIdle;
            end
          end
        end
        default: begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = 7'd0;
          w_pend_nxt  = 1'b0;
          w_led_nxt   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_1hz or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= 7'd0;
      r_pend  <= 1'b0;
      r_led   <= 1'b0;
      r_skip  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
      r_led   <= w_led_nxt;
      r_skip  <= w_skip_nxt;
    end
  end

  assign led        = r_led;
  assign busy       = (r_state != StIdle);
  assign owner      = (r_state == StChime) ? OWN_CHIME :
                      (r_state == StAlarm) ? OWN_ALARM : OWN_NONE;
  assign chime_skip = r_skip;

endmodule

// File: tb/tb_chime_scheduler.sv
// Directed and randomized checks of chime_scheduler against an activity-level LED model
// driven by a free-running time-of-day counter inside the bench.
module tb_chime_scheduler;

  localparam int AlarmLen = 60;

  logic       clk_1hz = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] hour = 5'd0;
  logic [5:0] minute = 6'd0;
  logic [5:0] second = 6'd0;
  logic       set_mode = 1'b0;
  logic       chime_en = 1'b0;
  logic       alarm_en = 1'b0;
  logic [4:0] alarm_hh = 5'd0;
  logic [5:0] alarm_mm = 6'd0;
  logic       alarm_stop = 1'b0;
  logic       led;
  logic       busy;
  logic [1:0] owner;
  logic       chime_skip;

  chime_scheduler #(
    .ALARM_LEN  (AlarmLen),
    .QUIET_START(23),
    .QUIET_END  (7)
  ) dut (
    .clk_1hz   (clk_1hz),
    .rst_n     (rst_n),
    .hour      (hour),
    .minute    (minute),
    .second    (second),
    .set_mode  (set_mode),
    .chime_en  (chime_en),
    .alarm_en  (alarm_en),
    .alarm_hh  (alarm_hh),
    .alarm_mm  (alarm_mm),
    .alarm_stop(alarm_stop),
    .led       (led),
    .busy      (busy),
    .owner     (owner),
    .chime_skip(chime_skip)
  );

  always #5 clk_1hz = ~clk_1hz;

  int n_assert = 0;
  int n_fail = 0;

  // Reference: who holds the LED (0 none, 1 chime, 2 alarm) and how many toggles remain.
  int m_who = 0;
  int m_left = 0;
  bit m_led = 1'b0;
  bit m_alarm_waiting = 1'b0;
  bit m_skip = 1'b0;

  function automatic int chime_toggles(int h);
    int nx = (h + 1) % 24;
    int n = nx % 12;
    if (n == 0) n = 12;
    return 2 * n;
  endfunction

  function automatic bit chime_muted(int h);
    int nx = (h + 1) % 24;
`ifdef CHIME_QUIET_EN
    return (nx >= 23) || (nx < 7);
`else
    return (nx < 0);
`endif
  endfunction

  task automatic model_reset();
    m_who = 0;
    m_left = 0;
    m_led = 1'b0;
    m_alarm_waiting = 1'b0;
    m_skip = 1'b0;
  endtask

  task automatic model_edge();
    bit chime_due;
    bit alarm_due;
    chime_due = chime_en && !set_mode && !chime_muted(int'(hour)) && minute == 6'd59 &&
                int'(second) == 60 - chime_toggles(int'(hour));
    alarm_due = alarm_en && !set_mode && hour == alarm_hh && minute == alarm_mm &&
                second == 6'd0;
    m_skip = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (set_mode) begin
      model_reset();
    end else if (m_who == 0) begin
      if (chime_due) begin
        m_who = 1;
        m_left = chime_toggles(int'(hour));
      end else if (alarm_due) begin
        m_who = 2;
        m_left = AlarmLen;
      end
    end else if (m_who == 1) begin
      m_led = !m_led;
      m_left = m_left - 1;
      if (alarm_due) m_alarm_waiting = 1'b1;
      if (m_left == 0) begin
        m_who = m_alarm_waiting ? 2 : 0;
        m_left = m_alarm_waiting ? AlarmLen : 0;
        m_alarm_waiting = 1'b0;
      end
    end else begin
      m_skip = chime_due;
      if (alarm_stop) begin
        m_who = 0;
        m_left = 0;
        m_led = 1'b0;
      end else begin
        m_led = !m_led;
        m_left = m_left - 1;
        if (m_left == 0) m_who = 0;
      end
    end
  endtask

  task automatic check(string tag, logic [7:0] observed, logic [7:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at %0d:%0d:%0d", tag, observed, expected,
             hour, minute, second);
    end
  endtask

  task automatic check_all();
    check("led", 8'(led), 8'(m_led));
    check("busy", 8'(busy), 8'(m_who != 0));
    check("owner", 8'(owner), 8'(m_who));
    check("chime_skip", 8'(chime_skip), 8'(m_skip));
  endtask

  task automatic advance_time();
    if (second == 6'd59) begin
      second = 6'd0;
      if (minute == 6'd59) begin
        minute = 6'd0;
        hour = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
      end else begin
        minute = minute + 6'd1;
      end
    end else begin
      second = second + 6'd1;
    end
  endtask

  task automatic tick();
    @(posedge clk_1hz);
    model_edge();
    @(negedge clk_1hz);
    check_all();
    advance_time();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_time(int h, int m, int s);
    hour = 5'(h);
    minute = 6'(m);
    second = 6'(s);
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk_1hz);
    check_all();
    rst_n = 1'b1;

    // Chime at 04:59:50, 10 toggles ending on 05:00:00
    chime_en = 1'b1;
    set_time(4, 59, 48);
    run(15);

    // Midnight rollover: 23:59:36 gives 24 toggles
    set_time(23, 59, 34);
    run(30);

    // Chime hands over to an alarm at 06:00 with no idle edge
    alarm_en = 1'b1;
    alarm_hh = 5'd6;
    alarm_mm = 6'd0;
    set_time(5, 59, 47);
    run(76);

    // Alarm stopped by the user after 7 toggles
    chime_en = 1'b0;
    alarm_hh = 5'd10;
    set_time(9, 59, 59);
    run(9);
    alarm_stop = 1'b1;
    run(1);
    alarm_stop = 1'b0;
    run(3);

    // Alarm running across 07:59:44 drops the chime
    chime_en = 1'b1;
    alarm_hh = 5'd7;
    alarm_mm = 6'd59;
    set_time(7, 58, 58);
    run(66);

    // set_mode aborts a running chime
    alarm_en = 1'b0;
    set_time(2, 59, 52);
    run(4);
    set_mode = 1'b1;
    run(1);
    set_mode = 1'b0;
    run(6);

    // Asynchronous reset in the middle of a chime at 04:59:55
    set_time(4, 59, 50);
    run(5);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("reset_led", 8'(led), 8'(0));
    check("reset_busy", 8'(busy), 8'(0));
    check("reset_owner", 8'(owner), 8'(0));
    @(negedge clk_1hz);
    rst_n = 1'b1;
    run(3);

    // Randomized windows around chime start seconds and alarm times
    for (int it = 0; it < 30; it++) begin
      int h;
      int s;
      h = int'($urandom_range(0, 23));
      chime_en = ($urandom_range(0, 3) != 0);
      alarm_en = $urandom_range(0, 1) != 0;
      alarm_hh = 5'(($urandom_range(0, 1) != 0) ? (h + 1) % 24 : h);
      alarm_mm = ($urandom_range(0, 1) != 0) ? 6'd0 : 6'd59;
      s = 60 - chime_toggles(h) - int'($urandom_range(0, 3));
      set_time(h, 59, s);
      for (int k = 0; k < 40; k++) begin
        alarm_stop = ($urandom_range(0, 15) == 0);
        set_mode = ($urandom_range(0, 63) == 0);
        tick();
      end
      alarm_stop = 1'b0;
      set_mode = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
